// File: rtl/cci_mpf_prim_counting_semaphore_cam_pkg.sv
// Shared defaults and width helpers for the counting-semaphore CAM.
// Slot, count and value types deliberately live inside the CAM module, because they depend on its parameters.
package cci_mpf_prim_counting_semaphore_cam_pkg;

    localparam int SEM_CAM_DEF_ENTRIES    = 8;
    localparam int SEM_CAM_DEF_IDX_BITS   = 9;
    localparam int SEM_CAM_DEF_CNT_BITS   = 3;
    localparam int SEM_CAM_DEF_TEST_PORTS = 2;

    // Width needed to count 0..n_entries busy slots inclusive.
    function automatic int sem_cam_busy_width(input int n_entries);
        return $clog2(n_entries + 1);
    endfunction

endpackage

// File: rtl/cci_mpf_prim_counting_semaphore_cam_alloc.sv
// Free-slot picker: returns the lowest-numbered free slot and whether any slot is free.
// Purely combinational.
module cci_mpf_prim_semaphore_cam_alloc #(
    parameter int N_ENTRIES = 8
)(
    input  logic [N_ENTRIES-1:0]         i_free,
    output logic [$clog2(N_ENTRIES)-1:0] o_idx,
    output logic                         o_any
);
    localparam int N_SLOT_BITS = $clog2(N_ENTRIES);

    // Scan from the top so the lowest free slot is the last one assigned.
    always_comb begin
        o_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (i_free[i]) begin
                o_idx = N_SLOT_BITS'(i);
            end
        end
    end

    assign o_any = |i_free;

endmodule

// File: rtl/cci_mpf_prim_counting_semaphore_cam.sv
// Counting-semaphore CAM: tracks reference counts for up to N_ENTRIES distinct index values,
// with N_TEST_PORTS independent lookups. All outputs come from registered state only.
module cci_mpf_prim_counting_semaphore_cam
    import cci_mpf_prim_counting_semaphore_cam_pkg::*;
#(
    parameter int N_ENTRIES    = SEM_CAM_DEF_ENTRIES,
    parameter int N_IDX_BITS   = SEM_CAM_DEF_IDX_BITS,
    parameter int N_CNT_BITS   = SEM_CAM_DEF_CNT_BITS,
    parameter int N_TEST_PORTS = SEM_CAM_DEF_TEST_PORTS
)(
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     set_en,
    input  logic [N_IDX_BITS-1:0]                    set_idx,
    output logic                                     set_rdy,
    input  logic                                     clear_en,
    input  logic [N_IDX_BITS-1:0]                    clear_idx,
    input  logic [N_TEST_PORTS-1:0][N_IDX_BITS-1:0]  test_idx,
    output logic [N_TEST_PORTS-1:0]                  is_set,
    output logic [N_TEST_PORTS-1:0][N_CNT_BITS-1:0]  test_cnt,
    output logic [sem_cam_busy_width(N_ENTRIES)-1:0] n_busy,
    output logic                                     full,
    output logic                                     err_set,
    output logic                                     err_clear
);
    localparam int N_SLOT_BITS = $clog2(N_ENTRIES);
    localparam int N_BUSY_BITS = sem_cam_busy_width(N_ENTRIES);

    typedef logic [N_SLOT_BITS-1:0] slot_t;
    typedef logic [N_CNT_BITS-1:0]  cnt_t;
    typedef logic [N_IDX_BITS-1:0]  idx_t;

    localparam cnt_t CMAX = '1;

    logic [N_ENTRIES-1:0] r_valid;
    cnt_t                 r_cnt [N_ENTRIES];
    idx_t                 r_val [N_ENTRIES];
    logic                 r_err_set;
    logic                 r_err_clear;

    logic [N_ENTRIES-1:0]   w_set_hit;
    logic [N_ENTRIES-1:0]   w_clr_hit;
    logic [N_ENTRIES-1:0]   w_inc;
    logic [N_ENTRIES-1:0]   w_dec;
    logic [N_ENTRIES-1:0]   w_alloc;
    logic                   w_set_any;
    logic                   w_clr_any;
    cnt_t                   w_set_hit_cnt;
    slot_t                  w_free_slot;
    logic                   w_any_free;
    logic [N_BUSY_BITS-1:0] w_busy;
    logic                   w_full;
    logic                   w_set_rdy;
    logic                   w_set_acc;

    genvar gi;

    // ---------------- Match against set/clear values ----------------
    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_match
            assign w_set_hit[gi] = r_valid[gi] && (r_val[gi] == set_idx);
            assign w_clr_hit[gi] = r_valid[gi] && (r_val[gi] == clear_idx);
        end
    endgenerate

    assign w_set_any = |w_set_hit;
    assign w_clr_any = |w_clr_hit;

    always_comb begin
        w_set_hit_cnt = '0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (w_set_hit[e]) begin
                w_set_hit_cnt = w_set_hit_cnt | r_cnt[e];
            end
        end
    end

    // ---------------- Occupancy ----------------
    always_comb begin
        w_busy = '0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (r_valid[e]) begin
                w_busy = w_busy + N_BUSY_BITS'(1);
            end
        end
    end

    assign w_full = (w_busy == N_BUSY_BITS'(N_ENTRIES));

    cci_mpf_prim_semaphore_cam_alloc #(
        .N_ENTRIES (N_ENTRIES)
    ) u_alloc (
        .i_free (~r_valid),
        .o_idx  (w_free_slot),
        .o_any  (w_any_free)
    );

    // Readiness looks only at stored state and set_idx, never at the enables,
    // so a clear in the same cycle cannot open a slot for the set.
    assign w_set_rdy = w_set_any ? (w_set_hit_cnt != CMAX) : w_any_free;
    assign w_set_acc = set_en && w_set_rdy;

    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_slot_ctl
            assign w_inc[gi]   = w_set_acc && w_set_hit[gi];
            assign w_dec[gi]   = clear_en && w_clr_hit[gi];
            assign w_alloc[gi] = w_set_acc && !w_set_any && (w_free_slot == slot_t'(gi));
        end
    endgenerate

    // ---------------- Slot state ----------------
    // An allocated slot was invalid, so it can never also be the clear target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int e = 0; e < N_ENTRIES; e++) begin
                r_cnt[e] <= '0;
            end
        end else begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                if (w_alloc[e]) begin
                    r_valid[e] <= 1'b1;
                    r_cnt[e]   <= cnt_t'(1);
                end else if (w_inc[e] && !w_dec[e]) begin
                    r_cnt[e] <= r_cnt[e] + cnt_t'(1);
                end else if (w_dec[e] && !w_inc[e]) begin
                    r_cnt[e] <= r_cnt[e] - cnt_t'(1);
                    if (r_cnt[e] == cnt_t'(1)) begin
                        r_valid[e] <= 1'b0;
                    end
                end
            end
        end
    end

    // Stored values are qualified by r_valid and need no reset.
    always_ff @(posedge clk) begin
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (w_alloc[e]) begin
                r_val[e] <= set_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_set   <= 1'b0;
            r_err_clear <= 1'b0;
        end else begin
            if (set_en && !w_set_rdy) begin
                r_err_set <= 1'b1;
            end
            if (clear_en && !w_clr_any) begin
                r_err_clear <= 1'b1;
            end
        end
    end

    // ---------------- Lookup ports ----------------
    generate
        for (gi = 0; gi < N_TEST_PORTS; gi++) begin : g_test
            logic w_t_hit;
            cnt_t w_t_cnt;

            always_comb begin
                w_t_hit = 1'b0;
                w_t_cnt = '0;
                for (int e = 0; e < N_ENTRIES; e++) begin
                    if (r_valid[e] && (r_val[e] == test_idx[gi])) begin
                        w_t_hit = 1'b1;
                        w_t_cnt = w_t_cnt | r_cnt[e];
                    end
                end
            end

            assign is_set[gi]   = w_t_hit;
            assign test_cnt[gi] = w_t_cnt;
        end
    endgenerate

    assign set_rdy   = w_set_rdy;
    assign n_busy    = w_busy;
    assign full      = w_full;
    assign err_set   = r_err_set;
    assign err_clear = r_err_clear;

`ifndef SYNTHESIS
    logic w_dup;

    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            for (int j = i + 1; j < N_ENTRIES; j++) begin
                if (r_valid[i] && r_valid[j] && (r_val[i] == r_val[j])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!w_dup) else $fatal(1, "semaphore CAM: duplicate value in two valid slots");
        end
    end
`endif

endmodule

// File: doc/cci_mpf_prim_counting_semaphore_cam.md
CCI_MPF_PRIM_COUNTING_SEMAPHORE_CAM -- requirements
Module: cci_mpf_prim_counting_semaphore_cam

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8: number of CAM slots, >=2.
REQ-002 SHALL have parameter N_IDX_BITS, default 9: width of tracked index values.
REQ-003 SHALL have parameter N_CNT_BITS, default 3: per-slot reference-count width; max count CMAX = 2**N_CNT_BITS-1.
REQ-004 SHALL have parameter N_TEST_PORTS, default 2: number of independent lookup ports.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock domain, all state updates on posedge clk.
- reset_n  in  1  asynchronous, active-low reset.
- set_en  in  1  increment the count for set_idx.
- set_idx  in  N_IDX_BITS  value to set.
- set_rdy  out  1  a set of set_idx is acceptable this cycle.
- clear_en  in  1  decrement the count for clear_idx.
- clear_idx  in  N_IDX_BITS  value to clear.
- test_idx  in  N_TEST_PORTS x N_IDX_BITS  lookup values.
- is_set  out  N_TEST_PORTS  test_idx[p] is held with count>=1.
- test_cnt  out  N_TEST_PORTS x N_CNT_BITS  current count for test_idx[p]; 0 on miss.
- n_busy  out  clog2(N_ENTRIES+1)  number of valid slots.
- full  out  1  all slots valid.
- err_set  out  1  sticky: set_en asserted while set_rdy low.
- err_clear  out  1  sticky: clear_en asserted for a value not held.

Function
REQ-006 SHALL hold at most one valid slot per distinct value; each slot stores value and count in 1..CMAX.
REQ-007 SHALL compute is_set, test_cnt, set_rdy, full and n_busy combinationally from registered state only; updates from cycle N are visible at cycle N+1.
REQ-008 SHALL drive set_rdy high when set_idx hits a slot with count<CMAX, or misses and full is low; set_rdy SHALL NOT depend on set_en or clear_en.
REQ-009 SHALL, on set_en with a hit, increment that slot's count by one.
REQ-010 SHALL, on set_en with a miss, allocate the lowest-numbered invalid slot, with value=set_idx and count=1.
REQ-011 SHALL, on clear_en with a hit, decrement the count; reaching 0 SHALL invalidate the slot.
REQ-012 SHALL, on clear_en with a miss, leave state unchanged and set err_clear.
REQ-013 SHALL, on set_en while set_rdy is low, leave state unchanged and set err_set.
REQ-014 SHALL, on simultaneous set and clear of the same held value, leave its count unchanged (net zero); on the same value not held, allocate with count 1 and set err_clear.
REQ-015 SHALL process simultaneous set and clear of different values independently; a slot freed by clear in cycle N is allocatable from cycle N+1 only (no bypass).
REQ-016 SHALL never let a count wrap: CMAX+1 and 0-1 are unreachable given REQ-008/REQ-012.
REQ-017 SHALL drive full = (n_busy == N_ENTRIES).
REQ-018 SHALL, in simulation only, fatal-assert that no two valid slots hold the same value.

Reset
REQ-019 SHALL, while reset_n is low, asynchronously clear all slot valid bits, counts, err_set and err_clear; slot values need no reset.
REQ-020 SHALL therefore present is_set=0, test_cnt=0, n_busy=0, full=0, set_rdy=1, err_*=0 during and after reset.
REQ-021 SHALL discard any set/clear in the cycle reset_n deasserts only if sampled with reset_n low; operation resumes on the first posedge with reset_n high.

Structure
REQ-022 SHALL place no types in a shared package; slot index, count and value typedefs are local to the module, derived from parameters.
REQ-023 SHALL instantiate one sub-module, cci_mpf_prim_semaphore_cam_alloc: N_ENTRIES-bit free-vector in, lowest free slot index and any-free out, purely combinational.

Verification (N_ENTRIES=4, N_IDX_BITS=8, N_CNT_BITS=2, N_TEST_PORTS=2)
REQ-024 Set 0x11 three times -> test 0x11 gives is_set=1, test_cnt=3, set_rdy=0 for 0x11; fourth set -> err_set=1, count stays 3.
REQ-025 Set 0x01,0x02,0x03,0x04 -> full=1, n_busy=4, set_rdy=0 for 0x05; clear 0x02 and set 0x05 same cycle -> 0x05 rejected, err_set=1; set 0x05 next cycle -> lands in slot 1.
REQ-026 With 0x20 count 1, same-cycle set and clear of 0x20 -> count remains 1, n_busy unchanged.
REQ-027 Clear 0x7F never set -> err_clear=1, n_busy unchanged; clear 0x33 at count 1 -> is_set=0 next cycle, n_busy decrements.
REQ-028 Fill to 3 slots, pulse reset_n low mid-cycle -> all outputs at reset values immediately, before next clk edge.
REQ-029 Random set/clear/test traffic 10k cycles vs. a reference-count model -> is_set/test_cnt/n_busy match every cycle, REQ-018 never fires.
